// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller.
//   state_e      : handshake FSM states (idle / requesting / in service)
//   NSrcDefault  : default number of interrupt sources
//   VecWDefault  : default vector width (2**VecWDefault >= NSrcDefault)
package int_pkg;

  localparam int unsigned NSrcDefault = 4;
  localparam int unsigned VecWDefault = 2;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StReq     = 2'b01,
    StService = 2'b10
  } state_e;

endpackage

// File: rtl/prio_enc.sv
// Find-first-set with a rotating start offset.
// Scans req starting at index 'start' upward, wrapping past NSRC-1 back to 0.
// Ports:
//   req   : request bits, one per source
//   start : index scanned first
//   found : at least one request bit is set
//   idx   : first set index encountered in scan order
module prio_enc
  import int_pkg::*;
#(
  parameter int unsigned NSRC  = NSrcDefault,
  parameter int unsigned VEC_W = VecWDefault
) (
  input  logic [NSRC-1:0]  req,
  input  logic [VEC_W-1:0] start,
  output logic             found,
  output logic [VEC_W-1:0] idx
);

  always_comb begin : scan
    logic [VEC_W-1:0] pos;
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      // j < NSRC <= 2**VEC_W, so the narrowing cast is lossless
      pos = VEC_W'((32'(start) + k) % NSRC);
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: latches rising edges of irq_in, masks them with a
// software-written enable register, and runs a single-level
// request / ack / end-of-interrupt handshake with the cpu.
// Build option: define INT_ROTATE_EN for rotating priority (search starts
// after the last acknowledged source); otherwise index 0 is highest priority.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   irq_in      : raw level request lines
//   cfg_we      : write strobe for the enable mask, cfg_data is the new mask
//   int_ack     : cpu accepts the current request
//   eoi         : cpu finished servicing
//   int_req     : interrupt request to cpu (registered)
//   int_vec     : index of requested / in-service source
//   in_service  : cpu is servicing an interrupt (registered)
//   pend_out    : pending register
//   mask_out    : current enable mask
module int_controller
  import int_pkg::*;
#(
  parameter int unsigned NSRC  = NSrcDefault,
  parameter int unsigned VEC_W = VecWDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NSRC-1:0]  irq_in,
  input  logic             cfg_we,
  input  logic [NSRC-1:0]  cfg_data,
  input  logic             int_ack,
  input  logic             eoi,
  output logic             int_req,
  output logic [VEC_W-1:0] int_vec,
  output logic             in_service,
  output logic [NSRC-1:0]  pend_out,
  output logic [NSRC-1:0]  mask_out
);

  logic [NSRC-1:0]  irq_prev_q;
  logic [NSRC-1:0]  pend_q, pend_d;
  logic [NSRC-1:0]  mask_q;
  logic [NSRC-1:0]  rise, clr, eligible;
  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             req_q, svc_q;
  logic             ack_fire;
  logic             enc_found;
  logic [VEC_W-1:0] enc_idx, enc_start;

  assign rise     = irq_in & ~irq_prev_q;
  assign eligible = pend_q & mask_q;
  assign ack_fire = (state_q == StReq) && int_ack;
  assign clr      = ack_fire ? (NSRC'(1) << vec_q) : '0;
  // A new edge on the bit being cleared wins, so it stays pending
  assign pend_d   = (pend_q & ~clr) | rise;

`ifdef INT_ROTATE_EN
  logic [VEC_W-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (ack_fire) begin
      ptr_q <= vec_q;
    end
  end

  // Wrap at 2**VEC_W is harmless: the encoder reduces modulo NSRC
  assign enc_start = ptr_q + VEC_W'(1);
`else
  assign enc_start = '0;
`endif

  prio_enc #(
    .NSRC  (NSRC),
    .VEC_W (VEC_W)
  ) u_prio_enc (
    .req   (eligible),
    .start (enc_start),
    .found (enc_found),
    .idx   (enc_idx)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    unique case (state_q)
      StIdle: begin
        if (enc_found) begin
          state_d = StReq;
          vec_d   = enc_idx;
        end
      end
      StReq: begin
        if (int_ack) state_d = StService;
      end
      StService: begin
        if (eoi) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev_q <= '0;
      pend_q     <= '0;
      mask_q     <= '0;
      state_q    <= StIdle;
      vec_q      <= '0;
      req_q      <= 1'b0;
      svc_q      <= 1'b0;
    end else begin
      irq_prev_q <= irq_in;
      pend_q     <= pend_d;
      if (cfg_we) mask_q <= cfg_data;
      state_q    <= state_d;
      vec_q      <= vec_d;
      req_q      <= (state_d == StReq);
      svc_q      <= (state_d == StService);
    end
  end

  assign int_req    = req_q;
  assign in_service = svc_q;
  assign int_vec    = vec_q;
  assign pend_out   = pend_q;
  assign mask_out   = mask_q;

endmodule
